// File: rtl/id_ex_stage_pkg.sv
// Shared types and constants for the ID/EX pipeline register and its forwarding unit.
package id_ex_stage_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned OP_W_DEF   = 6;

    // ALU opcode for ADD, also the idle opcode held in EX after reset
    localparam logic [OP_W_DEF-1:0] ADD_OP = 6'b011000;

    // Operand source select produced by the forwarding unit
    typedef enum logic [1:0] {
        FWD_NONE = 2'd0,
        FWD_EXM  = 2'd1,
        FWD_WB   = 2'd2
    } fwd_sel_e;

    // Control bits carried alongside an instruction in the EX stage
    typedef struct packed {
        logic valid;
        logic a_pc;
        logic b_imm;
        logic reg_wr;
        logic mem_rd;
        logic mem_wr;
    } ex_ctrl_t;

    // The younger producer (EX/MEM) wins when both stages write the same register
    function automatic fwd_sel_e fwd_pick(input logic exm_hit, input logic wb_hit);
        fwd_sel_e sel;
        sel = FWD_NONE;
        if (exm_hit) begin
            sel = FWD_EXM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/id_ex_stage_fwd_unit.sv
// Combinational forwarding selects for the two EX-stage source operands.
module id_ex_stage_fwd_unit
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] ex_rs1_i,
    input  logic [REG_AW-1:0] ex_rs2_i,
    input  logic [REG_AW-1:0] exm_rd_i,
    input  logic              exm_wr_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_wr_i,
    output fwd_sel_e          fwd_rs1_sel_c_o,
    output fwd_sel_e          fwd_rs2_sel_c_o
);

    logic exm_hit1;
    logic exm_hit2;
    logic wb_hit1;
    logic wb_hit2;

    // Match each source against the later-stage destinations; x0 is never forwarded
    always_comb begin
        exm_hit1 = 1'b0;
        exm_hit2 = 1'b0;
        wb_hit1  = 1'b0;
        wb_hit2  = 1'b0;
        if (exm_wr_i && (exm_rd_i != '0)) begin
            exm_hit1 = (exm_rd_i == ex_rs1_i);
            exm_hit2 = (exm_rd_i == ex_rs2_i);
        end
        if (wb_wr_i && (wb_rd_i != '0)) begin
            wb_hit1 = (wb_rd_i == ex_rs1_i);
            wb_hit2 = (wb_rd_i == ex_rs2_i);
        end
        fwd_rs1_sel_c_o = fwd_pick(exm_hit1, wb_hit1);
        fwd_rs2_sel_c_o = fwd_pick(exm_hit2, wb_hit2);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection and EX-stage operand forwarding.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned OP_W   = OP_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              id_valid_i,
    input  logic [XLEN-1:0]   id_pc_i,
    input  logic [XLEN-1:0]   id_rs1_data_i,
    input  logic [XLEN-1:0]   id_rs2_data_i,
    input  logic [XLEN-1:0]   id_imm_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [OP_W-1:0]   id_op_i,
    input  logic              id_use_rs1_i,
    input  logic              id_use_rs2_i,
    input  logic              id_a_pc_i,
    input  logic              id_b_imm_i,
    input  logic              id_reg_wr_i,
    input  logic              id_mem_rd_i,
    input  logic              id_mem_wr_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [REG_AW-1:0] exm_rd_i,
    input  logic              exm_wr_i,
    input  logic [XLEN-1:0]   exm_res_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    input  logic              wb_wr_i,
    input  logic [XLEN-1:0]   wb_data_i,
    output logic              id_stall_o,
    output logic [XLEN-1:0]   opr_a_alu_o,
    output logic [XLEN-1:0]   opr_b_alu_o,
    output logic [OP_W-1:0]   op_alu_o,
    output logic              ex_valid_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic              ex_reg_wr_o,
    output logic              ex_mem_rd_o,
    output logic              ex_mem_wr_o,
    output logic [XLEN-1:0]   ex_st_data_o
);

    // EX-stage state
    ex_ctrl_t          ctrl_q,     ctrl_d;
    logic [XLEN-1:0]   pc_q,       pc_d;
    logic [XLEN-1:0]   rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]   rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]   imm_q,      imm_d;
    logic [REG_AW-1:0] rs1_q,      rs1_d;
    logic [REG_AW-1:0] rs2_q,      rs2_d;
    logic [REG_AW-1:0] rd_q,       rd_d;
    logic [OP_W-1:0]   op_q,       op_d;

    logic              lu_c;
    logic [XLEN-1:0]   id_rs1_val_c;
    logic [XLEN-1:0]   id_rs2_val_c;
    logic [XLEN-1:0]   fwd_rs1_c;
    logic [XLEN-1:0]   fwd_rs2_c;
    fwd_sel_e          sel_rs1_c;
    fwd_sel_e          sel_rs2_c;

    id_ex_stage_fwd_unit #(
        .REG_AW (REG_AW)
    ) u_fwd_unit (
        .ex_rs1_i        (rs1_q),
        .ex_rs2_i        (rs2_q),
        .exm_rd_i        (exm_rd_i),
        .exm_wr_i        (exm_wr_i),
        .wb_rd_i         (wb_rd_i),
        .wb_wr_i         (wb_wr_i),
        .fwd_rs1_sel_c_o (sel_rs1_c),
        .fwd_rs2_sel_c_o (sel_rs2_c)
    );

    // Load-use hazard: a load in EX feeds a source the ID instruction reads
    always_comb begin
        lu_c = 1'b0;
        if (ctrl_q.valid && ctrl_q.mem_rd && (rd_q != '0) && id_valid_i) begin
            lu_c = (id_use_rs1_i && (id_rs1_i == rd_q)) ||
                   (id_use_rs2_i && (id_rs2_i == rd_q));
        end
        id_stall_o = (lu_c || stall_i) && !flush_i;
    end

    // Register file is written at the end of WB, so same-cycle writes bypass into capture
    always_comb begin
        id_rs1_val_c = id_rs1_data_i;
        id_rs2_val_c = id_rs2_data_i;
        if (wb_wr_i && (wb_rd_i != '0)) begin
            if (wb_rd_i == id_rs1_i) begin
                id_rs1_val_c = wb_data_i;
            end
            if (wb_rd_i == id_rs2_i) begin
                id_rs2_val_c = wb_data_i;
            end
        end
    end

    // Forwarded source operands and ALU operand selection
    always_comb begin
        fwd_rs1_c = rs1_data_q;
        fwd_rs2_c = rs2_data_q;
        case (sel_rs1_c)
            FWD_EXM: fwd_rs1_c = exm_res_i;
            FWD_WB:  fwd_rs1_c = wb_data_i;
            default: fwd_rs1_c = rs1_data_q;
        endcase
        case (sel_rs2_c)
            FWD_EXM: fwd_rs2_c = exm_res_i;
            FWD_WB:  fwd_rs2_c = wb_data_i;
            default: fwd_rs2_c = rs2_data_q;
        endcase
        opr_a_alu_o  = ctrl_q.a_pc  ? pc_q  : fwd_rs1_c;
        opr_b_alu_o  = ctrl_q.b_imm ? imm_q : fwd_rs2_c;
        ex_st_data_o = fwd_rs2_c;
    end

    // Control outputs are qualified by the EX valid bit
    always_comb begin
        op_alu_o    = op_q;
        ex_valid_o  = ctrl_q.valid;
        ex_rd_o     = rd_q;
        ex_reg_wr_o = ctrl_q.valid && ctrl_q.reg_wr;
        ex_mem_rd_o = ctrl_q.valid && ctrl_q.mem_rd;
        ex_mem_wr_o = ctrl_q.valid && ctrl_q.mem_wr;
    end

    // Next EX contents: flush > stall (hold, refresh operands) > load-use bubble > capture
    always_comb begin
        ctrl_d     = ctrl_q;
        pc_d       = pc_q;
        rs1_data_d = rs1_data_q;
        rs2_data_d = rs2_data_q;
        imm_d      = imm_q;
        rs1_d      = rs1_q;
        rs2_d      = rs2_q;
        rd_d       = rd_q;
        op_d       = op_q;
        if (flush_i) begin
            ctrl_d.valid = 1'b0;
        end else if (stall_i) begin
            // Producers may retire while held, so keep the values they delivered
            rs1_data_d = fwd_rs1_c;
            rs2_data_d = fwd_rs2_c;
        end else if (lu_c) begin
            ctrl_d.valid = 1'b0;
        end else begin
            ctrl_d.valid  = id_valid_i;
            ctrl_d.a_pc   = id_a_pc_i;
            ctrl_d.b_imm  = id_b_imm_i;
            ctrl_d.reg_wr = id_reg_wr_i;
            ctrl_d.mem_rd = id_mem_rd_i;
            ctrl_d.mem_wr = id_mem_wr_i;
            pc_d          = id_pc_i;
            rs1_data_d    = id_rs1_val_c;
            rs2_data_d    = id_rs2_val_c;
            imm_d         = id_imm_i;
            rs1_d         = id_rs1_i;
            rs2_d         = id_rs2_i;
            rd_d          = id_rd_i;
            op_d          = id_op_i;
        end
    end

    // EX-stage register bank
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q     <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            op_q       <= OP_W'(ADD_OP);
        end else begin
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
            op_q       <= op_d;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    localparam logic [5:0] OP_X = 6'h05;
    // Flag bits: use_rs1, use_rs2, a_pc, b_imm, reg_wr, mem_rd, mem_wr
    localparam logic [6:0] U1 = 7'b1000000;
    localparam logic [6:0] U2 = 7'b0100000;
    localparam logic [6:0] AP = 7'b0010000;
    localparam logic [6:0] BI = 7'b0001000;
    localparam logic [6:0] RW = 7'b0000100;
    localparam logic [6:0] MR = 7'b0000010;

    localparam int K_A = 0, K_B = 1, K_OP = 2, K_V = 3, K_S = 4, K_ST = 5,
                   K_RW = 6, K_MR = 7, K_MW = 8, K_RD = 9;

    logic        clk, reset_n;
    logic        id_valid_i;
    logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [4:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic [5:0]  id_op_i;
    logic        id_use_rs1_i, id_use_rs2_i, id_a_pc_i, id_b_imm_i;
    logic        id_reg_wr_i, id_mem_rd_i, id_mem_wr_i;
    logic        stall_i, flush_i;
    logic [4:0]  exm_rd_i, wb_rd_i;
    logic        exm_wr_i, wb_wr_i;
    logic [31:0] exm_res_i, wb_data_i;
    logic        id_stall_o;
    logic [31:0] opr_a_alu_o, opr_b_alu_o, ex_st_data_o;
    logic [5:0]  op_alu_o;
    logic        ex_valid_o, ex_reg_wr_o, ex_mem_rd_o, ex_mem_wr_o;
    logic [4:0]  ex_rd_o;

    id_ex_stage dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .id_valid_i    (id_valid_i),
        .id_pc_i       (id_pc_i),
        .id_rs1_data_i (id_rs1_data_i),
        .id_rs2_data_i (id_rs2_data_i),
        .id_imm_i      (id_imm_i),
        .id_rs1_i      (id_rs1_i),
        .id_rs2_i      (id_rs2_i),
        .id_rd_i       (id_rd_i),
        .id_op_i       (id_op_i),
        .id_use_rs1_i  (id_use_rs1_i),
        .id_use_rs2_i  (id_use_rs2_i),
        .id_a_pc_i     (id_a_pc_i),
        .id_b_imm_i    (id_b_imm_i),
        .id_reg_wr_i   (id_reg_wr_i),
        .id_mem_rd_i   (id_mem_rd_i),
        .id_mem_wr_i   (id_mem_wr_i),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .exm_rd_i      (exm_rd_i),
        .exm_wr_i      (exm_wr_i),
        .exm_res_i     (exm_res_i),
        .wb_rd_i       (wb_rd_i),
        .wb_wr_i       (wb_wr_i),
        .wb_data_i     (wb_data_i),
        .id_stall_o    (id_stall_o),
        .opr_a_alu_o   (opr_a_alu_o),
        .opr_b_alu_o   (opr_b_alu_o),
        .op_alu_o      (op_alu_o),
        .ex_valid_o    (ex_valid_o),
        .ex_rd_o       (ex_rd_o),
        .ex_reg_wr_o   (ex_reg_wr_o),
        .ex_mem_rd_o   (ex_mem_rd_o),
        .ex_mem_wr_o   (ex_mem_wr_o),
        .ex_st_data_o  (ex_st_data_o)
    );

    typedef struct {
        int unsigned cyc;
        string       nm;
        int          kind;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc;
    int          n_assert;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int kind);
        case (kind)
            K_A:     return opr_a_alu_o;
            K_B:     return opr_b_alu_o;
            K_OP:    return 32'(op_alu_o);
            K_V:     return 32'(ex_valid_o);
            K_S:     return 32'(id_stall_o);
            K_ST:    return ex_st_data_o;
            K_RW:    return 32'(ex_reg_wr_o);
            K_MR:    return 32'(ex_mem_rd_o);
            K_MW:    return 32'(ex_mem_wr_o);
            default: return 32'(ex_rd_o);
        endcase
    endfunction

    // Monitor: compare every expectation queued for the current cycle
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e   = sb.pop_front();
            act = actual(e.kind);
            n_assert++;
            if (e.cyc != cyc || act !== e.val) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", e.nm, act, e.val, cyc);
            end
        end
    end

    task automatic expect_o(input string nm, input int kind, input logic [31:0] val);
        exp_t e;
        e.cyc  = cyc;
        e.nm   = nm;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [31:0] pc, input logic [31:0] r1d,
                          input logic [31:0] r2d, input logic [31:0] imm, input logic [4:0] r1,
                          input logic [4:0] r2, input logic [4:0] rd, input logic [5:0] op,
                          input logic [6:0] fl);
        id_valid_i    = v;
        id_pc_i       = pc;
        id_rs1_data_i = r1d;
        id_rs2_data_i = r2d;
        id_imm_i      = imm;
        id_rs1_i      = r1;
        id_rs2_i      = r2;
        id_rd_i       = rd;
        id_op_i       = op;
        {id_use_rs1_i, id_use_rs2_i, id_a_pc_i, id_b_imm_i,
         id_reg_wr_i, id_mem_rd_i, id_mem_wr_i} = fl;
    endtask

    task automatic idle_id();
        set_id(1'b0, '0, '0, '0, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic set_fwd(input logic ew, input logic [4:0] er, input logic [31:0] eres,
                           input logic ww, input logic [4:0] wr, input logic [31:0] wd);
        exm_wr_i  = ew;
        exm_rd_i  = er;
        exm_res_i = eres;
        wb_wr_i   = ww;
        wb_rd_i   = wr;
        wb_data_i = wd;
    endtask

    task automatic clr_fwd();
        set_fwd(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached with %0d expectations pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        cyc      = 0;
        n_assert = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        stall_i  = 1'b0;
        flush_i  = 1'b0;
        idle_id();
        clr_fwd();

        // Reset state
        next_cycle();
        expect_o("rst_valid", K_V, 32'd0);
        expect_o("rst_op", K_OP, 32'(ADD_OP));
        expect_o("rst_stall", K_S, 32'd0);
        expect_o("rst_regwr", K_RW, 32'd0);
        expect_o("rst_memrd", K_MR, 32'd0);
        expect_o("rst_memwr", K_MW, 32'd0);
        next_cycle();
        reset_n = 1'b1;

        // ADD x3,x1,x2: rs1 from EX/MEM, rs2 from MEM/WB
        next_cycle();
        set_id(1'b1, 32'h100, 32'h111, 32'h222, '0, 5'd1, 5'd2, 5'd3, OP_X, U1 | U2 | RW);
        next_cycle();
        idle_id();
        set_fwd(1'b1, 5'd1, 32'h10, 1'b1, 5'd2, 32'h20);
        expect_o("add_a_exm", K_A, 32'h10);
        expect_o("add_b_wb", K_B, 32'h20);
        expect_o("add_st", K_ST, 32'h20);
        expect_o("add_valid", K_V, 32'd1);
        expect_o("add_op", K_OP, 32'(OP_X));
        expect_o("add_rd", K_RD, 32'd3);
        expect_o("add_regwr", K_RW, 32'd1);

        // EX/MEM beats MEM/WB on the same register; B takes immediate
        next_cycle();
        clr_fwd();
        set_id(1'b1, 32'h200, 32'h1234, 32'h5678, 32'h40, 5'd5, 5'd6, 5'd7, OP_X, U1 | U2 | BI | RW);
        next_cycle();
        idle_id();
        set_fwd(1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB);
        expect_o("tie_a_exm", K_A, 32'hAA);
        expect_o("tie_b_imm", K_B, 32'h40);
        expect_o("tie_st_reg", K_ST, 32'h5678);

        // x0 is never forwarded
        next_cycle();
        clr_fwd();
        set_id(1'b1, 32'h300, 32'h77, 32'h88, '0, 5'd0, 5'd0, 5'd8, OP_X, U1 | U2 | RW);
        next_cycle();
        idle_id();
        set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
        expect_o("x0_a_reg", K_A, 32'h77);
        expect_o("x0_b_reg", K_B, 32'h88);

        // A = PC while rs1 would forward; B from MEM/WB only
        next_cycle();
        clr_fwd();
        set_id(1'b1, 32'h1000, 32'h1, 32'h2, 32'h4, 5'd1, 5'd6, 5'd9, OP_X, U1 | U2 | AP | RW);
        next_cycle();
        idle_id();
        set_fwd(1'b1, 5'd1, 32'hDEAD, 1'b1, 5'd6, 32'h66);
        expect_o("apc_a_pc", K_A, 32'h1000);
        expect_o("apc_b_wb", K_B, 32'h66);
        expect_o("apc_st_wb", K_ST, 32'h66);

        // Regfile bypass at capture: WB writes x1 while ID reads it
        next_cycle();
        clr_fwd();
        set_id(1'b1, 32'h400, 32'h1, 32'h2, '0, 5'd1, 5'd2, 5'd10, OP_X, U1 | U2 | RW);
        set_fwd(1'b0, '0, '0, 1'b1, 5'd1, 32'hCAFE);
        next_cycle();
        idle_id();
        clr_fwd();
        expect_o("byp_a", K_A, 32'hCAFE);
        expect_o("byp_b", K_B, 32'h2);

        // Load-use: LW x4 in EX, ADD x5,x4,x1 in ID
        next_cycle();
        set_id(1'b1, 32'h500, 32'h1000, '0, 32'h8, 5'd1, 5'd0, 5'd4, ADD_OP, U1 | BI | RW | MR);
        next_cycle();
        set_id(1'b1, 32'h504, 32'h999, 32'h3, '0, 5'd4, 5'd1, 5'd5, OP_X, U1 | U2 | RW);
        expect_o("lu_stall", K_S, 32'd1);
        expect_o("lu_ld_valid", K_V, 32'd1);
        expect_o("lu_ld_memrd", K_MR, 32'd1);
        expect_o("lu_ld_a", K_A, 32'h1000);
        expect_o("lu_ld_b", K_B, 32'h8);
        next_cycle();
        expect_o("lu_bubble_valid", K_V, 32'd0);
        expect_o("lu_bubble_stall", K_S, 32'd0);
        expect_o("lu_bubble_memrd", K_MR, 32'd0);
        expect_o("lu_bubble_regwr", K_RW, 32'd0);
        next_cycle();
        idle_id();
        set_fwd(1'b0, '0, '0, 1'b1, 5'd4, 32'h4444);
        expect_o("lu_add_valid", K_V, 32'd1);
        expect_o("lu_add_a_wb", K_A, 32'h4444);
        expect_o("lu_add_b", K_B, 32'h3);
        expect_o("lu_add_rd", K_RD, 32'd5);

        // Downstream stall: held operand keeps the value WB delivered
        next_cycle();
        clr_fwd();
        set_id(1'b1, 32'h600, 32'h10, 32'h0, '0, 5'd1, 5'd2, 5'd11, OP_X, U1 | U2 | RW);
        next_cycle();
        idle_id();
        stall_i = 1'b1;
        set_fwd(1'b0, '0, '0, 1'b1, 5'd2, 32'h55);
        expect_o("stl1_b", K_B, 32'h55);
        expect_o("stl1_stall", K_S, 32'd1);
        expect_o("stl1_valid", K_V, 32'd1);
        next_cycle();
        clr_fwd();
        expect_o("stl2_b", K_B, 32'h55);
        expect_o("stl2_a", K_A, 32'h10);
        expect_o("stl2_stall", K_S, 32'd1);
        expect_o("stl2_valid", K_V, 32'd1);
        next_cycle();
        stall_i = 1'b0;
        expect_o("stl3_b", K_B, 32'h55);
        expect_o("stl3_stall", K_S, 32'd0);
        next_cycle();
        expect_o("stl_idle_valid", K_V, 32'd0);

        // Flush overrides both stall and load-use
        next_cycle();
        set_id(1'b1, 32'h700, 32'h1000, '0, 32'h8, 5'd1, 5'd0, 5'd4, ADD_OP, U1 | BI | RW | MR);
        next_cycle();
        set_id(1'b1, 32'h704, 32'h999, 32'h3, '0, 5'd4, 5'd1, 5'd5, OP_X, U1 | U2 | RW);
        stall_i = 1'b1;
        flush_i = 1'b1;
        expect_o("fl_stall", K_S, 32'd0);
        expect_o("fl_valid_before", K_V, 32'd1);
        next_cycle();
        stall_i = 1'b0;
        flush_i = 1'b0;
        idle_id();
        expect_o("fl_valid_after", K_V, 32'd0);
        expect_o("fl_memrd_after", K_MR, 32'd0);

        // Asynchronous reset in the middle of a load-use pair
        next_cycle();
        set_id(1'b1, 32'h800, 32'h1000, '0, 32'h8, 5'd1, 5'd0, 5'd4, OP_X, U1 | BI | RW | MR);
        next_cycle();
        set_id(1'b1, 32'h804, 32'h999, 32'h3, '0, 5'd4, 5'd1, 5'd5, OP_X, U1 | U2 | RW);
        reset_n = 1'b0;
        expect_o("mrst_valid", K_V, 32'd0);
        expect_o("mrst_op", K_OP, 32'(ADD_OP));
        expect_o("mrst_stall", K_S, 32'd0);
        expect_o("mrst_memrd", K_MR, 32'd0);
        next_cycle();
        reset_n = 1'b1;
        set_id(1'b1, 32'h900, 32'h31, 32'h32, '0, 5'd7, 5'd8, 5'd12, OP_X, U1 | U2 | RW);
        next_cycle();
        idle_id();
        expect_o("post_rst_valid", K_V, 32'd1);
        expect_o("post_rst_rd", K_RD, 32'd12);
        expect_o("post_rst_a", K_A, 32'h31);

        next_cycle();
        next_cycle();
        n_assert++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
